// File: rtl/rf_pkg.sv
// Shared defaults and types for the multi-port register file and its scoreboard.
package rf_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int ZERO_REG      = 0;

  typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_idx_t;
  typedef logic [XLEN_DEFAULT-1:0]          xlen_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, issue wins a same-cycle tie.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NUM_WR = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iss_valid_i,
  input  logic [AW-1:0]              iss_rd_i,
  input  logic [NUM_WR-1:0]          we_i,
  input  logic [NUM_WR-1:0][AW-1:0]  waddr_i,
  output logic [NREGS-1:0]           busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  // NOTE: every variable in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (we_i[w]) busy_d[waddr_i[w]] = 1'b0;
    end
    // Applied after the clears: a new producer supersedes the completing one.
    if (iss_valid_i) busy_d[iss_rd_i] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and a busy scoreboard.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter bit BYPASS = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_WR-1:0]                      we,
  input  logic [NUM_WR-1:0][$clog2(NREGS)-1:0]   waddr,
  input  logic [NUM_WR-1:0][XLEN-1:0]            wdata,
  input  logic [NUM_RD-1:0][$clog2(NREGS)-1:0]   raddr,
  output logic [NUM_RD-1:0][XLEN-1:0]            rdata,
  output logic [NUM_RD-1:0]                      rbusy,
  input  logic                                   iss_valid,
  input  logic [$clog2(NREGS)-1:0]               iss_rd,
  output logic [NREGS-1:0]                       busy_vec
);

  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0][XLEN-1:0] mem_q, mem_d;
  logic [NUM_RD-1:0]          wr_hit;
  logic [NUM_RD-1:0][XLEN-1:0] byp_data;

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NUM_WR (NUM_WR),
    .AW     (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .we_i        (we),
    .waddr_i     (waddr),
    .busy_o      (busy_vec)
  );

  // Ascending port order lets the highest-indexed port win an address conflict.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (we[w] && waddr[w] != AW'(ZERO_REG)) mem_d[waddr[w]] = wdata[w];
    end
    mem_d[ZERO_REG] = '0;
  end

  // NOTE: the array is cleared on reset because software may read any register before writing it.
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  always_comb begin
    wr_hit   = '0;
    byp_data = '0;
    rdata    = '0;
    rbusy    = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (we[w] && waddr[w] == raddr[r]) begin
          wr_hit[r]   = 1'b1;
          byp_data[r] = wdata[w];
        end
      end
      rdata[r] = mem_q[raddr[r]];
      rbusy[r] = busy_vec[raddr[r]];
      if (BYPASS && wr_hit[r]) begin
        rdata[r] = byp_data[r];
        rbusy[r] = 1'b0;
      end
      if (raddr[r] == AW'(ZERO_REG)) begin
        rdata[r] = '0;
        rbusy[r] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Drives a bypassing and a non-bypassing register file with the same stimulus against a reference model.
module tb_regfile_mp;
  import rf_pkg::*;

  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int NR  = NREGS_DEFAULT;

  logic clk = 1'b0;
  logic rst;
  logic [NWR-1:0]           we;
  reg_idx_t [NWR-1:0]       waddr;
  xlen_t    [NWR-1:0]       wdata;
  reg_idx_t [NRD-1:0]       raddr;
  logic                     iss_valid;
  reg_idx_t                 iss_rd;
  xlen_t    [NRD-1:0]       rdata_a, rdata_b;
  logic     [NRD-1:0]       rbusy_a, rbusy_b;
  logic     [NR-1:0]        busy_a, busy_b;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: architectural values and outstanding-producer flags.
  xlen_t m_reg [NR];
  bit    m_busy[NR];

  always #5 clk = ~clk;

  regfile_mp #(.NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_a)
  );

  regfile_mp #(.NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit written_now(input reg_idx_t a, output xlen_t d);
    bit hit = 0;
    d = '0;
    for (int w = 0; w < NWR; w++)
      if (we[w] && waddr[w] == a) begin hit = 1; d = wdata[w]; end
    return hit;
  endfunction

  function automatic xlen_t exp_rdata(input reg_idx_t a, input bit byp);
    xlen_t d;
    if (a == 0) return '0;
    if (byp && written_now(a, d)) return d;
    return m_reg[a];
  endfunction

  function automatic bit exp_rbusy(input reg_idx_t a, input bit byp);
    xlen_t d;
    if (a == 0) return 1'b0;
    if (byp && written_now(a, d)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [NR-1:0] exp_busy_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin m_reg[i] = '0; m_busy[i] = 1'b0; end
  endtask

  // Applies this cycle's inputs to the model as they take effect on the edge.
  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    for (int w = 0; w < NWR; w++) begin
      if (we[w] && waddr[w] != 0) m_reg[waddr[w]] = wdata[w];
      if (we[w]) m_busy[waddr[w]] = 1'b0;
    end
    if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
  endtask

  task automatic check_outputs();
    for (int r = 0; r < NRD; r++) begin
      check($sformatf("a.rdata[%0d]", r), 64'(rdata_a[r]), 64'(exp_rdata(raddr[r], 1'b1)));
      check($sformatf("b.rdata[%0d]", r), 64'(rdata_b[r]), 64'(exp_rdata(raddr[r], 1'b0)));
      check($sformatf("a.rbusy[%0d]", r), 64'(rbusy_a[r]), 64'(exp_rbusy(raddr[r], 1'b1)));
      check($sformatf("b.rbusy[%0d]", r), 64'(rbusy_b[r]), 64'(exp_rbusy(raddr[r], 1'b0)));
    end
    check("a.busy_vec", 64'(busy_a), 64'(exp_busy_vec()));
    check("b.busy_vec", 64'(busy_b), 64'(exp_busy_vec()));
  endtask

  // Inputs are set just after a falling edge; outputs are sampled well before the next rising edge.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; we = '0; iss_valid = 1'b0; iss_rd = '0;
    waddr = '0; wdata = '0;
  endtask

  initial begin
    idle();
    raddr = '0;
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);

    // Reset state
    idle();
    raddr[0] = 5'd5; raddr[1] = 5'd31;
    #1;
    check("rst.rdata0", 64'(rdata_a[0]), 64'h0);
    check("rst.rdata1", 64'(rdata_a[1]), 64'h0);
    check("rst.busy", 64'(busy_a), 64'h0);
    step();

    // Write with same-cycle read
    we[0] = 1'b1; waddr[0] = 5'd7; wdata[0] = 32'hDEADBEEF; raddr[0] = 5'd7;
    #1;
    check("byp.same", 64'(rdata_a[0]), 64'hDEADBEEF);
    check("nobyp.same", 64'(rdata_b[0]), 64'h0);
    step();
    idle();
    #1;
    check("byp.next", 64'(rdata_a[0]), 64'hDEADBEEF);
    check("nobyp.next", 64'(rdata_b[0]), 64'hDEADBEEF);
    step();

    // Register 0 protection
    we[0] = 1'b1; waddr[0] = 5'd0; wdata[0] = 32'h12345678; raddr[0] = 5'd0;
    step();
    idle(); iss_valid = 1'b1; iss_rd = 5'd0;
    step();
    idle();
    #1;
    check("x0.rdata", 64'(rdata_a[0]), 64'h0);
    check("x0.busy", 64'(busy_a[0]), 64'h0);
    step();

    // Scoreboard hazard on register 3
    iss_valid = 1'b1; iss_rd = 5'd3; raddr[0] = 5'd3;
    #1;
    check("haz.issue_cycle", 64'(rbusy_a[0]), 64'h0);
    step();
    idle();
    #1;
    check("haz.busy_a", 64'(rbusy_a[0]), 64'h1);
    check("haz.busy_b", 64'(rbusy_b[0]), 64'h1);
    step();
    we[1] = 1'b1; waddr[1] = 5'd3; wdata[1] = 32'h55;
    #1;
    check("haz.wb_a_busy", 64'(rbusy_a[0]), 64'h0);
    check("haz.wb_a_data", 64'(rdata_a[0]), 64'h55);
    check("haz.wb_b_busy", 64'(rbusy_b[0]), 64'h1);
    step();
    idle();
    #1;
    check("haz.after_b_busy", 64'(rbusy_b[0]), 64'h0);
    step();

    // Simultaneous set and clear on a busy register 9
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd9;
    we[0] = 1'b1; waddr[0] = 5'd9; wdata[0] = 32'h99; raddr[1] = 5'd9;
    step();
    idle();
    #1;
    check("setclr.busy9", 64'(busy_a[9]), 64'h1);
    check("setclr.data9", 64'(rdata_b[1]), 64'h99);
    step();

    // Write-port conflict
    we = 2'b11; waddr[0] = 5'd4; waddr[1] = 5'd4;
    wdata[0] = 32'hAAAA; wdata[1] = 32'hBBBB; raddr[0] = 5'd4;
    #1;
    check("conf.byp", 64'(rdata_a[0]), 64'hBBBB);
    step();
    idle();
    #1;
    check("conf.stored", 64'(rdata_b[0]), 64'hBBBB);
    step();

    // Reset with busy bits set and competing write/issue
    iss_valid = 1'b1; iss_rd = 5'd12;
    step();
    rst = 1'b1; iss_valid = 1'b1; iss_rd = 5'd13;
    we[0] = 1'b1; waddr[0] = 5'd4; wdata[0] = 32'hFFFF;
    step();
    idle();
    raddr[0] = 5'd4; raddr[1] = 5'd7;
    #1;
    check("rst2.busy", 64'(busy_a), 64'h0);
    check("rst2.reg4", 64'(rdata_b[0]), 64'h0);
    check("rst2.reg7", 64'(rdata_b[1]), 64'h0);
    step();

    // Randomized traffic with a narrow address range to provoke collisions
    for (int n = 0; n < 500; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      iss_valid = $urandom_range(0, 1) == 1;
      iss_rd    = reg_idx_t'($urandom_range(0, 15));
      for (int w = 0; w < NWR; w++) begin
        we[w]    = $urandom_range(0, 2) != 0;
        waddr[w] = reg_idx_t'($urandom_range(0, 15));
        wdata[w] = $urandom;
      end
      for (int r = 0; r < NRD; r++)
        raddr[r] = reg_idx_t'($urandom_range(0, 3) == 0 ? $urandom_range(0, NR - 1)
                                                        : $urandom_range(0, 15));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
